my_div64p: RTL
==============

Name: my_div64p

Overview:
- Iterative signed 64/32 divider; the inverse operation of the 32x32 signed multiplier block.
- Divides a 2*WIDTH-bit signed dividend by a WIDTH-bit signed divisor.
- Produces a WIDTH-bit quotient and a WIDTH-bit remainder, plus divide-by-zero and overflow flags.
- Uses valid/ready handshakes on both sides and sits beside the multipliers in the arithmetic datapath.
- Resolves one quotient bit per clock and uses no hard multipliers.

Parameters:
WIDTH, 32, divisor/quotient/remainder width; dividend is 2*WIDTH bits

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  reset, asynchronous, active-low
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
dividend  input  2*WIDTH  signed dividend (two's complement)
divisor  input  WIDTH  signed divisor (two's complement)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder, same sign as dividend (or zero)
div_by_zero  output  1  divisor was zero
overflow  output  1  true quotient does not fit WIDTH-bit signed

Behaviour:
- Interface: one clock (clk); reset_n is asynchronous, active-low.
- Reset (async assert):
  - State goes to IDLE.
  - out_valid, quotient, remainder, div_by_zero and overflow are all 0.
  - Internal shift/remainder registers are cleared.
  - in_ready = (state==IDLE), so it reads 1 during and after reset.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready=1.
  - Acceptance happens on a rising edge with in_valid && in_ready (call it edge 0).
  - At acceptance, register magnitudes: |dividend| as a 2*WIDTH-bit unsigned value (-2^63 maps to 2^63) and |divisor| as a WIDTH-bit unsigned value.
  - Also register q_neg = dividend sign XOR divisor sign, and r_neg = dividend sign.
- Divisor == 0 at acceptance: go directly to DONE with quotient = all ones, remainder = dividend[WIDTH-1:0], div_by_zero=1, overflow=0. out_valid is high in the cycle after edge 0.
- CALC:
  - Restoring radix-2 division over exactly 2*WIDTH cycles, MSB first.
  - Each cycle: partial remainder (WIDTH+1 bits) = {rem, next dividend bit}.
  - If that value >= |divisor|, subtract |divisor| and shift in quotient bit 1; otherwise shift in 0.
  - A counter runs 0..2*WIDTH-1; leave CALC when the counter reaches 2*WIDTH-1.
- FIX (1 cycle):
  - Apply signs: the quotient is negated if q_neg and the remainder if r_neg; a zero magnitude stays zero.
  - overflow=1 if the magnitude quotient exceeds 2^(WIDTH-1)-1 (positive result) or 2^(WIDTH-1) (negative result).
  - On overflow, quotient = low WIDTH bits of the signed true quotient; the remainder is still exact.
  - Load the output registers and go to DONE.
- Latency: out_valid rises after edge 2*WIDTH+1 (edge 65 for WIDTH=32).
- DONE:
  - out_valid=1.
  - quotient, remainder and flags are held stable until out_valid && out_ready.
  - On that edge: out_valid goes to 0 and state goes to IDLE. Outputs keep their last value; they are don't-care while out_valid=0.
- in_ready is 0 in CALC, FIX and DONE. There is no overlap of operations; the next acceptance is possible from the cycle after result handoff.
- in_valid is ignored when in_ready=0. Operand ports may change freely after acceptance because all operands are captured.
- Reset mid-operation: abort immediately, no out_valid, return to IDLE. The next operation after reset release must be correct.
- out_ready held high in DONE: handoff takes exactly one cycle.

Test Plan:
- 100 / 7 -> quotient=14, remainder=2, flags 0; out_valid first high after edge 65; in_ready=0 from edge 0 until handoff.
- -100 / 7 -> quotient=0xFFFFFFF2, remainder=0xFFFFFFFE. 100 / -7 -> quotient=0xFFFFFFF2, remainder=2.
- Divisor 0, dividend 0x1234 -> div_by_zero=1, quotient=0xFFFFFFFF, remainder=0x00001234, out_valid in the cycle after acceptance.
- Boundaries:
  - 0xFFFFFFFF_80000000 / 1 -> quotient=0x80000000, overflow=0.
  - 0x00000000_80000000 / 1 -> overflow=1, quotient=0x80000000.
  - 0x80000000_00000000 / -1 -> overflow=1.
  - 0x00000001_00000000 / 1 -> overflow=1, quotient=0, remainder=0.
- Backpressure and reset:
  - Hold out_ready=0 for 10 cycles in DONE -> outputs and flags stable, in_ready=0; then pulse out_ready and accept a new op on the next edge.
  - Assert reset_n=0 at cycle 20 of CALC -> out_valid never rises, in_ready=1; a following 100/7 gives 14 r 2.
- Cross-check with the 32x32 multiplier: 1000 random signed (a,b), b!=0.
  - Divide the multiplier's 64-bit product by b -> quotient=a, remainder=0, flags 0.
  - Random dividends are compared against a reference model for truncation semantics.

Source files
------------

// File: rtl/my_div64p_if.sv
// Operand/result handshake bundle for the iterative signed 64/32 divider.
interface my_div64p_if #(
  parameter int WIDTH = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [2*WIDTH-1:0]     dividend;
  logic [WIDTH-1:0]       divisor;
  logic                   out_valid;
  logic                   out_ready;
  logic [WIDTH-1:0]       quotient;
  logic [WIDTH-1:0]       remainder;
  logic                   div_by_zero;
  logic                   overflow;

  // Divider side: consumes operands, produces results.
  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );

  // Requester side: supplies operands, consumes results.
  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero, overflow
  );
endinterface

// File: rtl/my_div64p.sv
// Iterative signed 2*WIDTH / WIDTH divider: restoring radix-2, one quotient
// bit per clock on operand magnitudes, signs applied in a final fix-up cycle.
module my_div64p #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  my_div64p_if.slave  bus
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);
  localparam logic [DW-1:0] LIM_NEG  = DW'(1) << (WIDTH - 1);
  localparam logic [DW-1:0] LIM_POS  = LIM_NEG - DW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t             r_state;
  // Dividend magnitude shifts out of the top while quotient bits shift into
  // the bottom; after DW steps the register holds the quotient magnitude.
  logic [DW-1:0]      r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH-1:0]   r_rem;
  logic [CW-1:0]      r_cnt;
  logic               r_qneg;
  logic               r_rneg;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_rmd;
  logic               r_dbz;
  logic               r_ovf;

  logic [DW-1:0]      w_dvd_mag;
  logic [WIDTH-1:0]   w_dvs_mag;
  logic [WIDTH:0]     w_part;
  logic               w_ge;
  logic [WIDTH-1:0]   w_diff;
  logic [WIDTH-1:0]   w_qlo;
  logic [WIDTH-1:0]   w_q_signed;
  logic [WIDTH-1:0]   w_r_signed;
  logic               w_ovf;
  logic               w_accept;

  // Operand magnitudes; the most negative dividend maps to 2^(DW-1) unsigned.
  assign w_dvd_mag = bus.dividend[DW-1] ? (~bus.dividend + DW'(1)) : bus.dividend;
  assign w_dvs_mag = bus.divisor[WIDTH-1] ? (~bus.divisor + WIDTH'(1)) : bus.divisor;

  // One restoring step: trial-subtract the divisor from {rem, next bit}.
  // When the trial succeeds the difference is below |divisor|, so the low
  // WIDTH bits of the subtraction are exact.
  assign w_part = {r_rem, r_dvd[DW-1]};
  assign w_ge   = (w_part >= {1'b0, r_dvs});
  assign w_diff = w_part[WIDTH-1:0] - r_dvs;

  // Sign application and range check on the final magnitudes.
  assign w_qlo      = r_dvd[WIDTH-1:0];
  assign w_q_signed = r_qneg ? (~w_qlo + WIDTH'(1)) : w_qlo;
  assign w_r_signed = r_rneg ? (~r_rem + WIDTH'(1)) : r_rem;
  assign w_ovf      = r_qneg ? (r_dvd > LIM_NEG) : (r_dvd > LIM_POS);

  assign w_accept = bus.in_valid && (r_state == S_IDLE);

  assign bus.in_ready    = (r_state == S_IDLE);
  assign bus.out_valid   = r_out_valid;
  assign bus.quotient    = r_quo;
  assign bus.remainder   = r_rmd;
  assign bus.div_by_zero = r_dbz;
  assign bus.overflow    = r_ovf;

  // Control FSM, iteration datapath and registered result outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= S_IDLE;
      r_dvd       <= '0;
      r_dvs       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_qneg      <= 1'b0;
      r_rneg      <= 1'b0;
      r_out_valid <= 1'b0;
      r_quo       <= '0;
      r_rmd       <= '0;
      r_dbz       <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_qneg <= bus.dividend[DW-1] ^ bus.divisor[WIDTH-1];
            r_rneg <= bus.dividend[DW-1];
            r_dvd  <= w_dvd_mag;
            r_dvs  <= w_dvs_mag;
            r_rem  <= '0;
            r_cnt  <= '0;
            if (bus.divisor == '0) begin
              r_quo       <= '1;
              r_rmd       <= bus.dividend[WIDTH-1:0];
              r_dbz       <= 1'b1;
              r_ovf       <= 1'b0;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end
        end

        S_CALC: begin
          r_dvd <= {r_dvd[DW-2:0], w_ge};
          r_rem <= w_ge ? w_diff : w_part[WIDTH-1:0];
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CNT_LAST) begin
            r_state <= S_FIX;
          end
        end

        S_FIX: begin
          r_quo       <= w_q_signed;
          r_rmd       <= w_r_signed;
          r_dbz       <= 1'b0;
          r_ovf       <= w_ovf;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end

        S_DONE: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
